// File: rtl/uart_pkg.sv
// UART shared definitions: receiver/transmitter state encodings and frame constants.
// Pure declarations, no logic or latency of its own.
// No flow control; consumers decide their own backpressure.
package uart_pkg;

  // Number of data bits in one 8N1 frame.
  localparam int UART_DATA_BITS = 8;

  // 3-bit state encoding shared by the UART receiver and transmitter.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4,
    WAIT_HI = 3'd5
  } uart_state_e;

  // Count at which the start bit is re-checked: the middle of the bit.
  function automatic logic [7:0] half_bit_cnt(input int clks_per_bit);
    return 8'((clks_per_bit - 1) / 2);
  endfunction

  // Count at which a full bit period has elapsed.
  function automatic logic [7:0] last_bit_cnt(input int clks_per_bit);
    return 8'(clks_per_bit - 1);
  endfunction

endpackage : uart_pkg

// File: rtl/uart_rx_if.sv
// UART receive-side bundle: serial line in, byte strobe, activity and error flags out.
// Wires only, no latency.
// No backpressure: the byte side must take each strobe in the cycle it appears.
interface uart_rx_if;
  import uart_pkg::*;

  logic                      i_Rx_Serial;
  logic                      o_Rx_DV;
  logic [UART_DATA_BITS-1:0] o_Rx_Byte;
  logic                      o_Rx_Active;
  logic                      o_Rx_Frame_Err;

  // Receiver side: samples the line, produces byte and status.
  modport slave (
    input  i_Rx_Serial,
    output o_Rx_DV,
    output o_Rx_Byte,
    output o_Rx_Active,
    output o_Rx_Frame_Err
  );

  // Line driver / byte consumer side.
  modport master (
    output i_Rx_Serial,
    input  o_Rx_DV,
    input  o_Rx_Byte,
    input  o_Rx_Active,
    input  o_Rx_Frame_Err
  );

endinterface : uart_rx_if

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; resets to all-ones (idle line).
// Latency: 2 clock cycles.
// No backpressure: plain level pass-through.
module uart_sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_Clock,
  input  logic             i_Rst_N,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops; reset to 1 so an idle-high line never looks like a start bit.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_N) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : uart_sync_2ff

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, start-glitch rejection, framing-error flag.
// Latency: 2-cycle line sync, DV pulses at the middle of the stop bit.
// No backpressure: each byte/error is a one-cycle strobe, the byte is held until the next good frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic     i_Clock,
  input  logic     i_Rst_N,
  uart_rx_if.slave rx
);

  // Sampling points within a bit period.
  localparam logic [7:0] HALF_CNT = half_bit_cnt(CLKS_PER_BIT);
  localparam logic [7:0] LAST_CNT = last_bit_cnt(CLKS_PER_BIT);

  logic                      r_rx;
  uart_state_e               state_q;
  logic [7:0]                cnt_q;
  logic [2:0]                idx_q;
  logic [UART_DATA_BITS-1:0] data_q;
  logic [UART_DATA_BITS-1:0] byte_q;
  logic                      dv_q;
  logic                      active_q;
  logic                      ferr_q;

  // The FSM only ever looks at the synchronized copy of the line.
  uart_sync_2ff #(
    .WIDTH (1)
  ) u_sync (
    .i_Clock (i_Clock),
    .i_Rst_N (i_Rst_N),
    .d_i     (rx.i_Rx_Serial),
    .q_o     (r_rx)
  );

  // Frame FSM with bit-period counter, data shifter and registered strobes.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_N) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      idx_q    <= 3'd0;
      data_q   <= '0;
      byte_q   <= '0;
      dv_q     <= 1'b0;
      active_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      // Strobes are single-cycle: they drop unless re-asserted below.
      dv_q   <= 1'b0;
      ferr_q <= 1'b0;

      case (state_q)
        IDLE: begin
          cnt_q <= 8'd0;
          idx_q <= 3'd0;
          if (!r_rx) begin
            state_q <= START;
          end
        end

        // Re-check the line at mid start bit; a line back high was only a glitch.
        START: begin
          if (cnt_q == HALF_CNT) begin
            cnt_q <= 8'd0;
            if (!r_rx) begin
              state_q  <= DATA;
              active_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        // One full bit period between samples keeps each sample mid-bit, LSB first.
        DATA: begin
          if (cnt_q == LAST_CNT) begin
            cnt_q         <= 8'd0;
            data_q[idx_q] <= r_rx;
            if (idx_q == 3'd7) begin
              idx_q   <= 3'd0;
              state_q <= STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        // Mid stop bit: a high line completes the frame, a low line is a framing error.
        STOP: begin
          if (cnt_q == LAST_CNT) begin
            cnt_q    <= 8'd0;
            active_q <= 1'b0;
            if (r_rx) begin
              byte_q  <= data_q;
              dv_q    <= 1'b1;
              state_q <= CLEANUP;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= WAIT_HI;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        // Single cycle for the DV strobe to retire; the stop bit still has half a bit left.
        CLEANUP: begin
          cnt_q   <= 8'd0;
          state_q <= IDLE;
        end

        // A held-low (break) line must not be mistaken for a stream of start bits.
        WAIT_HI: begin
          cnt_q <= 8'd0;
          if (r_rx) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q  <= IDLE;
          cnt_q    <= 8'd0;
          idx_q    <= 3'd0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx.o_Rx_DV        = dv_q;
  assign rx.o_Rx_Byte      = byte_q;
  assign rx.o_Rx_Active    = active_q;
  assign rx.o_Rx_Frame_Err = ferr_q;

endmodule : uart_rx
